pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the MIPS core.
//  Computes next PC: sequential (PC+4), branch (PC+4 + sign_imm<<2) or jump ({PC+4[31:28],index,2'b00}).
//  Runs a req/ack handshake to instruction memory and honours pipeline stalls.
//  Issues one instruction per accepted fetch; sits between the control unit and instruction memory.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC after reset; bits [1:0] forced to 2'b00
//  MAX_WAIT  15             max cycles in S_REQ without ack before timeout (TIMEOUT_EN only), >=1
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  stall         in   1   hold PC; instruction at current PC not consumed
//  branch        in   1   current instruction is a conditional branch
//  zero          in   1   ALU zero flag; branch taken = branch & zero
//  jump          in   1   current instruction is J-type jump
//  sign_imm      in   32  sign-extended branch offset (words)
//  jump_index    in   26  jump target word index
//  imem_req      out  1   fetch request to instruction memory
//  imem_addr     out  32  fetch address (= pc)
//  imem_ack      in   1   instruction memory data valid for imem_addr
//  pc            out  32  current PC
//  pc_plus4      out  32  pc + 4, modulo 2^32
//  instr_valid   out  1   instruction at pc issued this cycle
//  imem_timeout  out  1   sticky fetch-timeout flag
// BEHAVIOUR
//  - States: S_RESET, S_REQ, S_HOLD, S_ERR. rst=1 at an edge -> S_RESET, pc=RESET_PC, counter=0,
//    imem_timeout=0, regardless of state (reset mid-fetch discards the pending request).
//  - Reset values: imem_req=0, instr_valid=0, imem_timeout=0, pc=RESET_PC, imem_addr=RESET_PC.
//  - S_RESET: one cycle, imem_req=0 -> S_REQ.
//  - S_REQ: imem_req=1 (combinational from state). instr_valid = imem_ack & ~stall (combinational).
//      ack & ~stall -> pc <= next_pc at edge; stay S_REQ (back-to-back fetch, 1 instr/cycle max).
//      ack & stall  -> pc held; -> S_HOLD. No ack -> stay S_REQ, pc held.
//  - S_HOLD: imem_req=0, instr_valid=0, pc held; stall=0 -> S_REQ (refetch same pc). Ack ignored.
//  - next_pc priority: jump > (branch & zero) > pc_plus4. branch/zero/jump/sign_imm/jump_index
//    are sampled only when instr_valid=1; ignored otherwise.
//  - Arithmetic: all 32-bit, wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0; negative offsets wrap).
//    Branch target uses pc_plus4 + {sign_imm[29:0],2'b00}; pc[1:0] always 2'b00.
//  - S_ERR (TIMEOUT_EN only): imem_req=0, instr_valid=0, pc held; exit only via rst.
//  - Latency: first imem_req cycle is 2nd cycle after rst deasserted; redirect visible on pc
//    the cycle after instr_valid.
// CONFIGURATION
//  - PC_FETCH_TIMEOUT_EN defined: wait counter counts consecutive S_REQ cycles with imem_ack=0;
//    cleared on ack or on leaving S_REQ. If MAX_WAIT consecutive no-ack cycles elapse, next edge
//    -> S_ERR, imem_timeout=1 (sticky until rst).
//  - Not defined: no counter, S_ERR unreachable, imem_timeout tied to 0; S_REQ waits forever.
// TESTING
//  1. rst 2 cycles, ack=1 always, no branch/jump -> imem_req 0 then 1; pc 0x0,0x4,0x8,0xC per cycle.
//  2. pc=0x10, branch=1 zero=1 sign_imm=0xFFFF_FFFF, ack -> next pc=0x10; zero=0 -> 0x14.
//  3. pc=0x1000_0000, jump=1 jump_index=0x40 (branch&zero also 1) -> next pc=0x1000_0100.
//  4. pc=0x20, ack & stall=1 for 3 cycles -> pc stays 0x20, req=0 in S_HOLD, then req=1 at 0x20.
//  5. pc=0xFFFF_FFFC, ack, no redirect -> pc=0x0000_0000, pc_plus4=0x4.
//  6. PC_FETCH_TIMEOUT_EN, MAX_WAIT=4, ack held 0 -> req=1 for 4 cycles, then imem_timeout=1,
//     req=0, stays until rst; rst -> timeout=0, pc=RESET_PC. Also rst mid-S_REQ -> S_RESET.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter and sequences instruction fetch: computes the
//   next PC (sequential, branch or jump), runs the req/ack handshake to
//   instruction memory and honours pipeline stalls.
//   Optional feature macro: PC_FETCH_TIMEOUT_EN enables the fetch-wait
//   counter, the S_ERR state and the sticky imem_timeout flag.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] sign_imm,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        imem_timeout
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // The PC is always word aligned, whatever the parameter says.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        wait_expired;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign imem_req    = (state == S_REQ);
    assign instr_valid = imem_req & imem_ack & ~stall;

    // Shifting the full word keeps only sign_imm[29:0]; the wrap is intended.
    assign branch_offset = sign_imm << 2;

    // Next-PC select: jump beats a taken branch, which beats sequential.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned and infers a latch.
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

`ifdef PC_FETCH_TIMEOUT_EN
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    // Last no-ack cycle of the allowed window: leave for S_ERR at this edge.
    assign wait_expired = (state == S_REQ) && !imem_ack &&
                          (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // Count consecutive unacknowledged request cycles.
    always_ff @(posedge clk) begin
        if (rst || state != S_REQ || imem_ack) begin
            wait_cnt <= '0;
        end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // S_ERR is only left through reset, so the state itself is the sticky flag.
    assign imem_timeout = (state == S_ERR);
`else
    assign wait_expired = 1'b0;
    assign imem_timeout = 1'b0;
`endif

    // Fetch FSM and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= S_RESET;
            pc    <= RESET_PC_ALIGNED;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (instr_valid) begin
                        pc <= next_pc;
                    end else if (imem_ack && stall) begin
                        state <= S_HOLD;
                    end else if (wait_expired) begin
                        state <= S_ERR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state <= S_REQ;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
//   Directed-vector bench for pc_fetch_sequencer. Inputs change 1 ns after a
//   rising edge; outputs are sampled 1 ns after that, well away from the edge.
//   Define PC_FETCH_TIMEOUT_EN for both files to exercise the timeout path.
module tb_pc_fetch_sequencer;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] sign_imm;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        imem_timeout;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .sign_imm     (sign_imm),
        .jump_index   (jump_index),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .imem_timeout (imem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time to drive inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic no_redirect();
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        sign_imm   = 32'h0;
        jump_index = 26'h0;
    endtask

    // Reset two cycles, release; returns with the DUT in S_RESET.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        imem_ack = 1'b1;
        no_redirect();

        // ---- Reset values and sequential fetch ----
        tick();
        tick();
        settle();
        check("rst_req",     32'(imem_req),     32'd0);
        check("rst_valid",   32'(instr_valid),  32'd0);
        check("rst_timeout", 32'(imem_timeout), 32'd0);
        check("rst_pc",      pc,                32'h0);
        check("rst_addr",    imem_addr,         32'h0);
        rst = 1'b0;
        settle();
        check("sreset_req", 32'(imem_req), 32'd0);
        tick();
        settle();
        check("first_req",   32'(imem_req),    32'd1);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("seq_pc0",     pc,               32'h0);
        tick(); settle(); check("seq_pc4", pc, 32'h4);
        tick(); settle(); check("seq_pc8", pc, 32'h8);
        tick(); settle(); check("seq_pcC", pc, 32'hC);
        check("seq_plus4", pc_plus4, 32'h10);

        // ---- Jump to 0x10, then branch taken with -1 offset, not taken ----
        jump = 1'b1; jump_index = 26'h4;
        tick(); settle(); check("jump_0x10", pc, 32'h10);
        no_redirect();
        branch = 1'b1; zero = 1'b1; sign_imm = 32'hFFFF_FFFF;
        tick(); settle(); check("br_taken_neg1", pc, 32'h10);
        zero = 1'b0;
        tick(); settle(); check("br_not_taken", pc, 32'h14);

        // ---- Branch to 0x1000_0000, then jump beats taken branch ----
        zero = 1'b1; sign_imm = 32'h03FF_FFFA;
        tick(); settle(); check("br_far", pc, 32'h1000_0000);
        jump = 1'b1; jump_index = 26'h40;
        tick(); settle(); check("jump_prio", pc, 32'h1000_0100);

        // ---- Negative branch back down to 0x20 ----
        jump = 1'b0; jump_index = 26'h0; sign_imm = 32'hFBFF_FFC7;
        tick(); settle(); check("br_back_0x20", pc, 32'h20);
        no_redirect();

        // ---- Stall with ack: hold 3 cycles, then refetch the same pc ----
        stall = 1'b1;
        settle();
        check("stall_valid", 32'(instr_valid), 32'd0);
        tick(); settle();
        check("hold_req1", 32'(imem_req), 32'd0);
        check("hold_pc1",  pc,            32'h20);
        jump = 1'b1; jump_index = 26'h3FF;
        tick(); settle();
        check("hold_req2",    32'(imem_req),    32'd0);
        check("hold_valid2",  32'(instr_valid), 32'd0);
        check("hold_ignore",  pc,               32'h20);
        no_redirect();
        stall = 1'b0;
        settle();
        check("hold_req3", 32'(imem_req), 32'd0);
        tick(); settle();
        check("refetch_req",   32'(imem_req),    32'd1);
        check("refetch_pc",    pc,               32'h20);
        check("refetch_valid", 32'(instr_valid), 32'd1);
        tick(); settle(); check("after_refetch", pc, 32'h24);

        // ---- Redirect ignored while waiting for ack ----
        imem_ack = 1'b0; jump = 1'b1; jump_index = 26'h0;
        settle();
        check("noack_valid", 32'(instr_valid), 32'd0);
        tick(); settle(); check("noack_pc", pc, 32'h24);
        check("noack_req", 32'(imem_req), 32'd1);
        no_redirect();
        imem_ack = 1'b1;

        // ---- Reset mid-fetch, then wrap at the top of the address space ----
        imem_ack = 1'b0;
        rst = 1'b1;
        tick(); settle();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_pc",  pc,            32'h0);
        imem_ack = 1'b1;
        do_reset();
        tick(); settle();
        check("wrap_start", pc, 32'h0);
        branch = 1'b1; zero = 1'b1; sign_imm = 32'hFFFF_FFFE;
        tick(); settle();
        check("wrap_top",       pc,       32'hFFFF_FFFC);
        check("wrap_top_plus4", pc_plus4, 32'h0);
        no_redirect();
        tick(); settle();
        check("wrap_pc",    pc,       32'h0);
        check("wrap_plus4", pc_plus4, 32'h4);

        // ---- Unacknowledged fetch ----
        do_reset();
        tick();
        imem_ack = 1'b0;
        settle();
`ifdef PC_FETCH_TIMEOUT_EN
        for (int i = 0; i < MAX_WAIT; i++) begin
            check($sformatf("wait_req%0d", i), 32'(imem_req), 32'd1);
            check($sformatf("wait_to%0d", i), 32'(imem_timeout), 32'd0);
            tick(); settle();
        end
        check("to_flag", 32'(imem_timeout), 32'd1);
        check("to_req",  32'(imem_req),     32'd0);
        imem_ack = 1'b1;
        tick(); tick(); settle();
        check("to_sticky", 32'(imem_timeout), 32'd1);
        check("to_req2",   32'(imem_req),     32'd0);
        check("to_pc",     pc,                32'h0);
        rst = 1'b1;
        tick(); settle();
        check("to_rst_flag", 32'(imem_timeout), 32'd0);
        check("to_rst_pc",   pc,                32'h0);
        rst = 1'b0;
        tick(); settle();
        check("to_rst_req", 32'(imem_req), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        settle();
        check("wait_req",     32'(imem_req),     32'd1);
        check("wait_timeout", 32'(imem_timeout), 32'd0);
        check("wait_pc",      pc,                32'h0);
        imem_ack = 1'b1;
        settle();
        check("late_ack_valid", 32'(instr_valid), 32'd1);
        tick(); settle();
        check("late_ack_pc", pc, 32'h4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
